// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters,
// with one operation in flight and a private carry flag per requester.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [2*WIDTH-1:0] req_a,
  input  logic [2*WIDTH-1:0] req_b,
  input  logic [7:0]         req_opcode,
  input  logic [1:0]         req_use_carry,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic               alu_ic,
  output logic [3:0]         alu_opcode,
  input  logic [WIDTH-1:0]   alu_out,
  input  logic               alu_oc,
  input  logic               alu_oo,
  output logic [1:0]         rsp_valid,
  input  logic [1:0]         rsp_ready,
  output logic [WIDTH-1:0]   rsp_out,
  output logic               rsp_oc,
  output logic               rsp_oo
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_ptr;
  logic               r_owner;
  logic [1:0]         r_carry;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [3:0]         r_opcode;
  logic               r_ic;
  logic [WIDTH-1:0]   r_out;
  logic               r_oc;
  logic               r_oo;

  logic               w_grant;
  logic               w_accept;
  logic [WIDTH-1:0]   w_sel_a;
  logic [WIDTH-1:0]   w_sel_b;
  logic [3:0]         w_sel_opcode;
  logic               w_sel_ic;

  // On a tie the requester not granted last wins; otherwise whoever is valid.
  assign w_grant  = (&req_valid) ? ~r_ptr : req_valid[1];
  assign w_accept = reset_n && (r_state == S_IDLE) && (|req_valid);

  assign w_sel_a      = w_grant ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
  assign w_sel_b      = w_grant ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
  assign w_sel_opcode = w_grant ? req_opcode[7:4] : req_opcode[3:0];
  assign w_sel_ic     = w_grant ? (req_use_carry[1] & r_carry[1])
                                : (req_use_carry[0] & r_carry[0]);

  always_comb begin
    req_ready = 2'b00;
    if (w_accept) begin
      req_ready[w_grant] = 1'b1;
    end
  end

  always_comb begin
    rsp_valid = 2'b00;
    if (r_state == S_RESP) begin
      rsp_valid[r_owner] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (|req_valid) w_next = S_EXEC;
      S_EXEC:  w_next = S_RESP;
      S_RESP:  if (rsp_ready[r_owner]) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_ptr    <= 1'b1;
      r_owner  <= 1'b0;
      r_carry  <= 2'b00;
      r_a      <= '0;
      r_b      <= '0;
      r_opcode <= '0;
      r_ic     <= 1'b0;
      r_out    <= '0;
      r_oc     <= 1'b0;
      r_oo     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a      <= w_sel_a;
        r_b      <= w_sel_b;
        r_opcode <= w_sel_opcode;
        r_ic     <= w_sel_ic;
        r_owner  <= w_grant;
        r_ptr    <= w_grant;
      end
      // The ALU gets the whole EXEC cycle; its result is captured at the end.
      if (r_state == S_EXEC) begin
        r_out            <= alu_out;
        r_oc             <= alu_oc;
        r_oo             <= alu_oo;
        r_carry[r_owner] <= alu_oc;
      end
    end
  end

  assign alu_a      = r_a;
  assign alu_b      = r_b;
  assign alu_opcode = r_opcode;
  assign alu_ic     = r_ic;
  assign rsp_out    = r_out;
  assign rsp_oc     = r_oc;
  assign rsp_oo     = r_oo;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with an adder stub standing in for the ALU.
module tb_alu_arbiter;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [1:0]     req_valid;
  logic [1:0]     req_ready;
  logic [2*W-1:0] req_a;
  logic [2*W-1:0] req_b;
  logic [7:0]     req_opcode;
  logic [1:0]     req_use_carry;
  logic [W-1:0]   alu_a;
  logic [W-1:0]   alu_b;
  logic           alu_ic;
  logic [3:0]     alu_opcode;
  logic [W-1:0]   alu_out;
  logic           alu_oc;
  logic           alu_oo;
  logic [1:0]     rsp_valid;
  logic [1:0]     rsp_ready;
  logic [W-1:0]   rsp_out;
  logic           rsp_oc;
  logic           rsp_oo;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_opcode(req_opcode),
    .req_use_carry(req_use_carry),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ic(alu_ic), .alu_opcode(alu_opcode),
    .alu_out(alu_out), .alu_oc(alu_oc), .alu_oo(alu_oo),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_out(rsp_out), .rsp_oc(rsp_oc), .rsp_oo(rsp_oo)
  );

  // ALU stub: out = a + b + ic, carry-out and signed overflow.
  always_comb begin
    {alu_oc, alu_out} = {1'b0, alu_a} + {1'b0, alu_b} + {{W{1'b0}}, alu_ic};
    alu_oo = (alu_a[W-1] == alu_b[W-1]) && (alu_out[W-1] != alu_a[W-1]);
  end

  typedef struct {
    int         port;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic       uc;
    logic       ic;
    logic [W-1:0] out;
    logic       oc;
    logic       oo;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic set_req(input int p, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic uc);
    req_valid[p]          = 1'b1;
    req_a[p*W +: W]       = a;
    req_b[p*W +: W]       = b;
    req_opcode[p*4 +: 4]  = 4'(p + 3);
    req_use_carry[p]      = uc;
  endtask

  // One full operation; returns at the falling edge inside the RESP cycle.
  task automatic do_op(input string nm, input int p, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic uc, input logic ic_e,
                       input logic [W-1:0] out_e, input logic oc_e, input logic oo_e);
    logic ok;
    logic [1:0] exp_v;
    exp_v = 2'b00;
    exp_v[p] = 1'b1;
    @(posedge clk); #1;
    req_valid = 2'b00;
    set_req(p, a, b, uc);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req_ready[p]) begin
        ok = 1'b1;
        break;
      end
    end
    chk({nm, " accept"}, {63'd0, ok}, 64'd1);
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(negedge clk);
    chk({nm, " alu_a"}, 64'(alu_a), 64'(a));
    chk({nm, " alu_b"}, 64'(alu_b), 64'(b));
    chk({nm, " alu_ic"}, 64'(alu_ic), 64'(ic_e));
    chk({nm, " alu_opcode"}, 64'(alu_opcode), 64'(p + 3));
    chk({nm, " ready_exec"}, 64'(req_ready), 64'd0);
    @(negedge clk);
    chk({nm, " rsp_valid"}, 64'(rsp_valid), 64'(exp_v));
    chk({nm, " rsp_out"}, 64'(rsp_out), 64'(out_e));
    chk({nm, " rsp_oc"}, 64'(rsp_oc), 64'(oc_e));
    chk({nm, " rsp_oo"}, 64'(rsp_oo), 64'(oo_e));
  endtask

  initial begin
    logic [1:0] ev;
    logic [1:0] er;
    //          port a             b             uc    ic    out           oc    oo
    vecs[0] = '{0, 32'd5,        32'd7,        1'b0, 1'b0, 32'd12,       1'b0, 1'b0};
    vecs[1] = '{1, 32'hFFFF_FFFF, 32'd1,       1'b0, 1'b0, 32'd0,        1'b1, 1'b0};
    vecs[2] = '{0, 32'h7FFF_FFFF, 32'd1,       1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    vecs[3] = '{1, 32'd0,        32'd0,        1'b1, 1'b1, 32'd1,        1'b0, 1'b0};
    vecs[4] = '{0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'hFFFF_FFFE, 1'b1, 1'b0};
    vecs[5] = '{0, 32'd1,        32'd2,        1'b1, 1'b1, 32'd4,        1'b0, 1'b0};
    vecs[6] = '{1, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'd0,      1'b1, 1'b1};
    vecs[7] = '{0, 32'd0,        32'd0,        1'b1, 1'b0, 32'd0,        1'b0, 1'b0};
    vecs[8] = '{1, 32'd0,        32'd0,        1'b1, 1'b1, 32'd1,        1'b0, 1'b0};

    reset_n = 1'b0;
    req_valid = 2'b11;
    req_a = '0; req_b = '0; req_opcode = '0; req_use_carry = '0;
    rsp_ready = 2'b11;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset req_ready", 64'(req_ready), 64'd0);
    chk("reset rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset alu_a", 64'(alu_a), 64'd0);
    chk("reset rsp_out", 64'(rsp_out), 64'd0);
    @(posedge clk); #1;
    req_valid = 2'b00;
    reset_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i].port, vecs[i].a, vecs[i].b, vecs[i].uc,
            vecs[i].ic, vecs[i].out, vecs[i].oc, vecs[i].oo);
    end

    // Contention: last grant was port 1, so port 0 goes first.
    @(posedge clk); #1;
    set_req(0, 32'd1, 32'd1, 1'b0);
    set_req(1, 32'd2, 32'd2, 1'b0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      ev = ((i / 3) % 2 == 0) ? 2'b01 : 2'b10;
      er = (i % 3 == 0) ? ev : 2'b00;
      chk($sformatf("cont%0d req_ready", i), 64'(req_ready), 64'(er));
      er = (i % 3 == 2) ? ev : 2'b00;
      chk($sformatf("cont%0d rsp_valid", i), 64'(rsp_valid), 64'(er));
      if (i % 3 == 1)
        chk($sformatf("cont%0d alu_a", i), 64'(alu_a), (ev == 2'b01) ? 64'd1 : 64'd2);
      if (i % 3 == 2)
        chk($sformatf("cont%0d rsp_out", i), 64'(rsp_out), (ev == 2'b01) ? 64'd2 : 64'd4);
    end
    @(posedge clk); #1;
    req_valid = 2'b00;

    // Backpressure in RESP.
    rsp_ready = 2'b00;
    set_req(0, 32'd3, 32'd4, 1'b0);
    @(negedge clk);
    chk("bp accept", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(posedge clk); #1;
    set_req(1, 32'd10, 32'd20, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("bp%0d rsp_valid", k), 64'(rsp_valid), 64'd1);
      chk($sformatf("bp%0d rsp_out", k), 64'(rsp_out), 64'd7);
      chk($sformatf("bp%0d req_ready", k), 64'(req_ready), 64'd0);
    end
    @(posedge clk); #1;
    rsp_ready = 2'b11;
    @(negedge clk);
    chk("bp release rsp_valid", 64'(rsp_valid), 64'd1);
    @(negedge clk);
    chk("bp idle rsp_valid", 64'(rsp_valid), 64'd0);
    chk("bp idle req_ready", 64'(req_ready), 64'd2);
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(negedge clk);
    @(negedge clk);
    chk("bp next rsp_valid", 64'(rsp_valid), 64'd2);
    chk("bp next rsp_out", 64'(rsp_out), 64'd30);

    // Reset during EXEC after a carry-setting op.
    do_op("carry_set", 1, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    @(posedge clk); #1;
    set_req(1, 32'd5, 32'd5, 1'b0);
    @(negedge clk);
    chk("rst accept", 64'(req_ready), 64'd2);
    @(posedge clk); #1;
    req_valid = 2'b00;
    reset_n = 1'b0;
    @(negedge clk);
    chk("rst exec alu_a", 64'(alu_a), 64'd5);
    chk("rst req_ready low", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("rst%0d rsp_valid", k), 64'(rsp_valid), 64'd0);
    end
    chk("rst alu_a cleared", 64'(alu_a), 64'd0);
    chk("rst rsp_out cleared", 64'(rsp_out), 64'd0);
    @(posedge clk); #1;
    set_req(0, 32'd0, 32'd0, 1'b1);
    set_req(1, 32'd0, 32'd0, 1'b1);
    @(negedge clk);
    chk("rst tie winner", 64'(req_ready), 64'd1);
    req_valid = 2'b00;
    do_op("rst carry1", 1, 32'd0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0);

    @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
